// File: rtl/bpf_dac_pkg.sv
// Shared types, default widths and the DAC word formatter for the BPF interpolation DAC transmitter.
`timescale 1ns/1ps
package bpf_dac_pkg;

   localparam int unsigned DATA_W_DEF  = 14;
   localparam int unsigned FRAME_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_CS_HOLD,
      ST_WAIT_HALF
   } state_t;

   // Two's complement to offset binary, left-justified in the DAC frame.
   function automatic logic [FRAME_W_DEF-1:0] to_dac_word(input logic [DATA_W_DEF-1:0] d);
      return {~d[DATA_W_DEF-1], d[DATA_W_DEF-2:0], {(FRAME_W_DEF-DATA_W_DEF){1'b0}}};
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
`timescale 1ns/1ps
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         meta   <= din;
         sync   <= meta;
         sync_d <= sync;
         pulse  <= sync & ~sync_d;
      end
   end

endmodule

// File: rtl/bpf_interp_dac_tx.sv
// Sends the interpolated midpoint and then the current filter word to a serial DAC
// once per 325 kHz tick, giving a 650 kS/s output stream.
`timescale 1ns/1ps
module bpf_interp_dac_tx
   import bpf_dac_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned FRAME_W  = FRAME_W_DEF,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned HALF_CNT = 77
) (
   input  logic              clk50MHz,
   input  logic              rst_n,
   input  logic              clk325kHz,
   input  logic              enable,
   input  logic [DATA_W-1:0] out_cur,
   input  logic [DATA_W-1:0] out_inter,
   output logic              dac_cs_n,
   output logic              dac_sclk,
   output logic              dac_sdi,
   output logic              busy,
   output logic              overrun
);

   localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
   localparam int unsigned BIT_W  = $clog2(FRAME_W + 1);
   localparam int unsigned HALF_W = $clog2(HALF_CNT + 1);

   // A full frame must fit before the second frame is due.
   if ((2 * CLK_DIV * (FRAME_W + 1) + 1) >= HALF_CNT) begin : g_bad_timing
      $error("bpf_interp_dac_tx: frame does not fit in HALF_CNT");
   end
   if ((DATA_W != DATA_W_DEF) || (FRAME_W != FRAME_W_DEF)) begin : g_bad_width
      $error("bpf_interp_dac_tx: word widths must match bpf_dac_pkg");
   end

   state_t             state, state_n;
   logic [DIV_W-1:0]   div_cnt, div_n;
   logic [BIT_W-1:0]   bit_cnt, bit_n;
   logic [HALF_W-1:0]  half_cnt, half_n;
   logic               pass2, pass2_n;
   logic [FRAME_W-1:0] sr, sr_n;
   logic [DATA_W-1:0]  hold_cur, hold_cur_n;
   logic [DATA_W-1:0]  hold_inter, hold_inter_n;
   logic               cs_n_n, sclk_n, sdi_n, busy_n, overrun_n;
   logic               tick;
   logic               div_last;

   sync_edge_det u_tick (
      .clk   (clk50MHz),
      .rst_n (rst_n),
      .din   (clk325kHz),
      .pulse (tick)
   );

   assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

   // State and output registers
   always_ff @(posedge clk50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         half_cnt   <= '0;
         pass2      <= 1'b0;
         sr         <= '0;
         hold_cur   <= '0;
         hold_inter <= '0;
         dac_cs_n   <= 1'b1;
         dac_sclk   <= 1'b0;
         dac_sdi    <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_n;
         div_cnt    <= div_n;
         bit_cnt    <= bit_n;
         half_cnt   <= half_n;
         pass2      <= pass2_n;
         sr         <= sr_n;
         hold_cur   <= hold_cur_n;
         hold_inter <= hold_inter_n;
         dac_cs_n   <= cs_n_n;
         dac_sclk   <= sclk_n;
         dac_sdi    <= sdi_n;
         busy       <= busy_n;
         overrun    <= overrun_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n      = state;
      div_n        = div_cnt;
      bit_n        = bit_cnt;
      half_n       = half_cnt;
      pass2_n      = pass2;
      sr_n         = sr;
      hold_cur_n   = hold_cur;
      hold_inter_n = hold_inter;
      cs_n_n       = dac_cs_n;
      sclk_n       = dac_sclk;
      sdi_n        = dac_sdi;
      overrun_n    = overrun;

      if (state != ST_IDLE) begin
         half_n = half_cnt + HALF_W'(1);
      end

      unique case (state)
         ST_IDLE: begin
            half_n = '0;
            if (tick && enable) begin
               hold_cur_n   = out_cur;
               hold_inter_n = out_inter;
               pass2_n      = 1'b0;
               state_n      = ST_LOAD;
            end
         end
         ST_LOAD: begin
            sr_n    = to_dac_word(pass2 ? hold_cur : hold_inter);
            sdi_n   = sr_n[FRAME_W-1];
            cs_n_n  = 1'b0;
            sclk_n  = 1'b0;
            div_n   = '0;
            bit_n   = '0;
            state_n = ST_CS_SETUP;
         end
         ST_CS_SETUP: begin
            if (div_last) begin
               div_n   = '0;
               sclk_n  = 1'b1;
               state_n = ST_SHIFT;
            end else begin
               div_n = div_cnt + DIV_W'(1);
            end
         end
         ST_SHIFT: begin
            // Data advances on the falling edge; exit after the low half of the last period.
            if (div_last) begin
               div_n = '0;
               if (dac_sclk) begin
                  sclk_n = 1'b0;
                  sr_n   = {sr[FRAME_W-2:0], 1'b0};
                  sdi_n  = sr[FRAME_W-2];
                  bit_n  = bit_cnt + BIT_W'(1);
               end else if (bit_cnt == BIT_W'(FRAME_W)) begin
                  cs_n_n  = 1'b1;
                  sdi_n   = 1'b0;
                  state_n = ST_CS_HOLD;
               end else begin
                  sclk_n = 1'b1;
               end
            end else begin
               div_n = div_cnt + DIV_W'(1);
            end
         end
         ST_CS_HOLD: begin
            if (div_last) begin
               div_n   = '0;
               state_n = (pass2 || !enable) ? ST_IDLE : ST_WAIT_HALF;
            end else begin
               div_n = div_cnt + DIV_W'(1);
            end
         end
         ST_WAIT_HALF: begin
            if (!enable) begin
               state_n = ST_IDLE;
            end else if (half_cnt == HALF_W'(HALF_CNT - 1)) begin
               pass2_n = 1'b1;
               half_n  = '0;
               state_n = ST_LOAD;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (!enable) begin
         overrun_n = 1'b0;
      end else if (tick && (state != ST_IDLE)) begin
         overrun_n = 1'b1;
      end

      busy_n = (state_n != ST_IDLE);
   end

endmodule

// File: tb/tb_bpf_interp_dac_tx.sv
// Randomised scoreboard bench for bpf_interp_dac_tx: stimulus pushes expected DAC words,
// a monitor decodes the serial frames and pops/compares them.
`timescale 1ns/1ps
module tb_bpf_interp_dac_tx;

   localparam int CLK_DIV  = 2;
   localparam int HALF_CNT = 77;
   localparam int FRAME_W  = 16;

   logic        clk50MHz  = 1'b0;
   logic        rst_n     = 1'b0;
   logic        clk325kHz = 1'b0;
   logic        enable    = 1'b0;
   logic [13:0] out_cur   = '0;
   logic [13:0] out_inter = '0;
   logic        dac_cs_n, dac_sclk, dac_sdi, busy, overrun;

   bpf_interp_dac_tx dut (
      .clk50MHz  (clk50MHz),
      .rst_n     (rst_n),
      .clk325kHz (clk325kHz),
      .enable    (enable),
      .out_cur   (out_cur),
      .out_inter (out_inter),
      .dac_cs_n  (dac_cs_n),
      .dac_sclk  (dac_sclk),
      .dac_sdi   (dac_sdi),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #10 clk50MHz = ~clk50MHz;

   int cyc = 0;
   always @(posedge clk50MHz) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   int          cs_fall_q[$];
   int          frames_seen = 0;

   // DAC code: the signed sample shifted up by half scale, times four for left justification.
   function automatic logic [15:0] model_word(input int d);
      return 16'((d + 8192) * 4);
   endfunction

   function automatic int rand_sample();
      return int'($urandom_range(0, 16383)) - 8192;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   task automatic check_true(input string name, input bit cond);
      n_cmp++;
      if (!cond) begin
         n_err++;
         $display("FAIL %s: condition got 0, expected 1 at cycle %0d", name, cyc);
      end
   endtask

   task automatic wait_busy(input logic lvl, input int budget, input string name);
      int n = 0;
      while (busy !== lvl && n < budget) begin
         @(negedge clk50MHz);
         n++;
      end
      if (busy !== lvl) check_true(name, 1'b0);
   endtask

   task automatic wait_cs(input logic lvl, input int budget, input string name);
      int n = 0;
      while (dac_cs_n !== lvl && n < budget) begin
         @(negedge clk50MHz);
         n++;
      end
      if (dac_cs_n !== lvl) check_true(name, 1'b0);
   endtask

   // Raise clk325kHz with new words at an arbitrary phase relative to clk50MHz.
   task automatic edge325(input int inter, input int cur);
      @(negedge clk50MHz);
      out_inter = 14'(inter);
      out_cur   = 14'(cur);
      #($urandom_range(1, 8));
      clk325kHz = 1'b1;
   endtask

   task automatic send_pair(input int inter, input int cur);
      exp_q.push_back(model_word(inter));
      exp_q.push_back(model_word(cur));
      edge325(inter, cur);
      wait_busy(1'b1, 10, "busy_rise_timeout");
      repeat (5) @(negedge clk50MHz);
      clk325kHz = 1'b0;
      wait_busy(1'b0, 250, "busy_fall_timeout");
      repeat (5) @(negedge clk50MHz);
   endtask

   // Frame decoder and scoreboard consumer
   initial begin : monitor
      logic        p_cs     = 1'b1;
      logic        p_sclk   = 1'b0;
      logic        p_sdi    = 1'b0;
      logic        in_frame = 1'b0;
      logic [15:0] sh       = '0;
      int          rises    = 0;
      int          chg      = 0;
      int          rise_cyc = 0;
      forever begin
         @(negedge clk50MHz);
         if (!rst_n) begin
            in_frame = 1'b0;
         end else begin
            if (p_cs && !dac_cs_n) begin
               in_frame = 1'b1;
               sh       = '0;
               rises    = 0;
               cs_fall_q.push_back(cyc);
            end
            if (in_frame && !p_sclk && dac_sclk) begin
               check_true("sdi_setup", (cyc - chg) >= CLK_DIV);
               sh       = {sh[14:0], dac_sdi};
               rises++;
               rise_cyc = cyc;
            end
            if (in_frame && p_sclk && !dac_sclk)
               check_true("sdi_hold", (chg < rise_cyc) && ((cyc - rise_cyc) >= CLK_DIV));
            if (in_frame && !p_cs && dac_cs_n) begin
               in_frame = 1'b0;
               frames_seen++;
               check("sclk_rises", rises, FRAME_W);
               if (exp_q.size() == 0) check_true("unexpected_frame", 1'b0);
               else check("frame_word", sh, exp_q.pop_front());
            end
         end
         if (dac_sdi != p_sdi) chg = cyc;
         p_cs   = dac_cs_n;
         p_sclk = dac_sclk;
         p_sdi  = dac_sdi;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int f0;
      // Reset values
      repeat (3) @(negedge clk50MHz);
      check("rst_cs_n", dac_cs_n, 1);
      check("rst_sclk", dac_sclk, 0);
      check("rst_sdi", dac_sdi, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (5) @(negedge clk50MHz);

      // Midpoint 0 then full-scale positive; check the half-period spacing
      cs_fall_q.delete();
      send_pair(0, 8191);
      check("t1_frame_count", cs_fall_q.size(), 2);
      if (cs_fall_q.size() >= 2) check("t1_half_spacing", cs_fall_q[1] - cs_fall_q[0], HALF_CNT);
      else check_true("t1_half_spacing_missing", 1'b0);

      // Full-scale negative midpoint, -1 current
      send_pair(-8192, -1);
      for (int i = 0; i < 4; i++) send_pair(rand_sample(), rand_sample());
      check("t2_overrun", overrun, 0);

      // Free-running asynchronous 325 kHz clock, 100 periods
      cs_fall_q.delete();
      f0 = frames_seen;
      @(negedge clk50MHz);
      #3.3;
      for (int k = 0; k < 100; k++) begin
         realtime tr;
         int      ci, cu, n;
         ci = rand_sample();
         cu = rand_sample();
         exp_q.push_back(model_word(ci));
         exp_q.push_back(model_word(cu));
         out_inter = 14'(ci);
         out_cur   = 14'(cu);
         clk325kHz = 1'b1;
         tr        = $realtime;
         n         = 0;
         do begin
            @(negedge clk50MHz);
            n++;
         end while (dac_cs_n && n < 10);
         if (dac_cs_n) check_true("t3_cs_fall_timeout", 1'b0);
         else check_true("t3_tick_latency",
                         ($realtime - 10.0 - tr) >= 80.0 && ($realtime - 10.0 - tr) <= 100.0);
         #(tr + 1538.0 - $realtime);
         clk325kHz = 1'b0;
         #(tr + 3077.0 - $realtime);
      end
      wait_busy(1'b0, 250, "t3_idle_timeout");
      repeat (5) @(negedge clk50MHz);
      check("t3_frames", frames_seen - f0, 200);
      check("t3_cs_falls", cs_fall_q.size(), 200);
      check("t3_overrun", overrun, 0);

      // Extra edge while busy: overrun set and sticky, pair unaffected
      exp_q.push_back(model_word(1234));
      exp_q.push_back(model_word(-4321));
      edge325(1234, -4321);
      wait_busy(1'b1, 10, "t4_busy_rise_timeout");
      repeat (10) @(negedge clk50MHz);
      clk325kHz = 1'b0;
      repeat (20) @(negedge clk50MHz);
      out_inter = 14'(77);
      out_cur   = 14'(-77);
      clk325kHz = 1'b1;
      repeat (8) @(negedge clk50MHz);
      check("t4_overrun_set", overrun, 1);
      clk325kHz = 1'b0;
      wait_busy(1'b0, 250, "t4_busy_fall_timeout");
      repeat (20) @(negedge clk50MHz);
      check("t4_overrun_sticky", overrun, 1);
      enable = 1'b0;
      @(negedge clk50MHz);
      check("t4_overrun_clear", overrun, 0);
      enable = 1'b1;
      repeat (5) @(negedge clk50MHz);

      // Asynchronous reset in the middle of frame 1
      exp_q.push_back(model_word(-2000));
      exp_q.push_back(model_word(3000));
      edge325(-2000, 3000);
      wait_cs(1'b0, 10, "t5_cs_fall_timeout");
      repeat (2 + 4 * 7 + 1) @(negedge clk50MHz);
      #3;
      rst_n = 1'b0;
      #1;
      check("t5_cs_n", dac_cs_n, 1);
      check("t5_sclk", dac_sclk, 0);
      check("t5_sdi", dac_sdi, 0);
      check("t5_busy", busy, 0);
      exp_q.delete();
      clk325kHz = 1'b0;
      repeat (3) @(negedge clk50MHz);
      rst_n = 1'b1;
      repeat (3) @(negedge clk50MHz);
      send_pair(rand_sample(), rand_sample());

      // Enable dropped in WAIT_HALF: no second frame, busy falls next cycle
      cs_fall_q.delete();
      exp_q.push_back(model_word(4095));
      edge325(4095, -4096);
      wait_busy(1'b1, 10, "t6_busy_rise_timeout");
      clk325kHz = 1'b0;
      wait_cs(1'b0, 10, "t6_cs_fall_timeout");
      wait_cs(1'b1, 100, "t6_cs_rise_timeout");
      repeat (4) @(negedge clk50MHz);
      check("t6_busy_in_wait", busy, 1);
      enable = 1'b0;
      @(negedge clk50MHz);
      check("t6_busy_fall", busy, 0);
      repeat (120) @(negedge clk50MHz);
      check("t6_single_frame", cs_fall_q.size(), 1);
      enable = 1'b1;
      repeat (5) @(negedge clk50MHz);

      // Enable dropped mid-SHIFT: frame completes, then idle
      cs_fall_q.delete();
      exp_q.push_back(model_word(-1));
      edge325(-1, 1);
      wait_busy(1'b1, 10, "t6b_busy_rise_timeout");
      clk325kHz = 1'b0;
      wait_cs(1'b0, 10, "t6b_cs_fall_timeout");
      repeat (20) @(negedge clk50MHz);
      enable = 1'b0;
      wait_cs(1'b1, 100, "t6b_cs_rise_timeout");
      wait_busy(1'b0, 10, "t6b_busy_fall_timeout");
      repeat (120) @(negedge clk50MHz);
      check("t6b_single_frame", cs_fall_q.size(), 1);
      enable = 1'b1;
      repeat (5) @(negedge clk50MHz);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
